// File: rtl/byte_unstriping_rx_p_if.sv
// Handshake/status bundle for byte_unstriping_rx_p: striped lane input side,
// serialised byte output side, and the error/flag sideband.
interface byte_unstriping_rx_p_if #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int DEPTH  = 4
);
   localparam int LANE_W = $clog2(LANES);
   localparam int LVL_W  = $clog2(DEPTH) + 1;

   logic [LANES-1:0]        in_valid;
   logic [LANES*DATA_W-1:0] in_data;
   logic                    in_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_W-1:0]       out_data;
   logic [LANE_W-1:0]       out_lane;
   logic                    out_sop;
   logic [LVL_W-1:0]        level;
   logic                    clr_flags;
   logic                    overflow;
   logic                    skew_err;
   logic [7:0]              err_count;

   modport slave (
      input  in_valid, in_data, out_ready, clr_flags,
      output in_ready, out_valid, out_data, out_lane, out_sop,
             level, overflow, skew_err, err_count
   );

   modport master (
      output in_valid, in_data, out_ready, clr_flags,
      input  in_ready, out_valid, out_data, out_lane, out_sop,
             level, overflow, skew_err, err_count
   );
endinterface

// File: rtl/byte_unstriping_rx_p.sv
// Collects whole stripes of LANES bytes into a DEPTH-deep buffer and replays them
// one byte per cycle, lane 0 first. Define UNSTRIPE_ERR_COUNT_EN for the skew-error counter.
module byte_unstriping_rx_p #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   byte_unstriping_rx_p_if.slave  bus
);
   localparam int LANE_W   = $clog2(LANES);
   localparam int AW       = $clog2(DEPTH);
   localparam int LVL_W    = AW + 1;
   localparam int STRIPE_W = LANES * DATA_W;

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q, state_d;
   logic [LANE_W-1:0]   idx_q, idx_d;
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]    level_q;
   logic [STRIPE_W-1:0] mem_q [DEPTH];
   logic                overflow_q, skew_q;

   logic                all_valid, any_valid, can_push, push, pop, skew_hit;
   logic [STRIPE_W-1:0] head;
   logic                out_valid, out_sop;
   logic [DATA_W-1:0]   out_data;
   logic [LANE_W-1:0]   out_lane;

   assign all_valid = &bus.in_valid;
   assign any_valid = |bus.in_valid;
   // Held low during reset so the source never sees a ready buffer mid-reset.
   assign can_push  = reset && (level_q < LVL_W'(DEPTH));
   assign push      = all_valid && can_push;
   assign skew_hit  = any_valid && !all_valid;
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pop       = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_lane  = '0;
      out_sop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               state_d = SEND;
               idx_d   = '0;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            out_data  = head[idx_q*DATA_W +: DATA_W];
            out_lane  = idx_q;
            out_sop   = (idx_q == '0);
            if (bus.out_ready) begin
               if (idx_q == LANE_W'(LANES-1)) begin
                  pop   = 1'b1;
                  idx_d = '0;
                  // Stay in SEND when another stripe remains (or arrives this edge).
                  if (level_q == LVL_W'(1) && !push)
                     state_d = IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
         skew_q     <= 1'b0;
      end else if (bus.clr_flags) begin
         overflow_q <= 1'b0;
         skew_q     <= 1'b0;
      end else begin
         if (all_valid && !can_push)
            overflow_q <= 1'b1;
         if (skew_hit)
            skew_q <= 1'b1;
      end
   end

`ifdef UNSTRIPE_ERR_COUNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_cnt_q <= '0;
      else if (bus.clr_flags)
         err_cnt_q <= '0;
      else if (skew_hit && err_cnt_q != 8'hFF)
         err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign bus.err_count = err_cnt_q;
`else
   assign bus.err_count = 8'd0;
`endif

   assign bus.in_ready  = can_push;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_lane  = out_lane;
   assign bus.out_sop   = out_sop;
   assign bus.level     = level_q;
   assign bus.overflow  = overflow_q;
   assign bus.skew_err  = skew_q;
endmodule

// File: tb/tb_byte_unstriping_rx_p.sv
// Directed bench for byte_unstriping_rx_p: stimulus pushes expected bytes into a
// scoreboard queue, an independent monitor pops and compares on every accepted byte.
module tb_byte_unstriping_rx_p;
   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int DEPTH  = 4;

`ifdef UNSTRIPE_ERR_COUNT_EN
   localparam int ERR_ONE = 1;
   localparam int ERR_SAT = 255;
`else
   localparam int ERR_ONE = 0;
   localparam int ERR_SAT = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   byte_unstriping_rx_p_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

   byte_unstriping_rx_p #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] lane;
      logic       sop;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   seen  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stripe(input logic [31:0] s);
      bus.in_valid = '1;
      bus.in_data  = s;
      if (bus.in_ready) begin
         for (int k = 0; k < LANES; k++)
            exp_q.push_back('{d: s[k*8 +: 8], lane: k[1:0], sop: (k == 0)});
      end
      step();
      bus.in_valid = '0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++)
         step();
      check(name, exp_q.size(), 0);
      repeat (4) step();
   endtask

   // Monitor: compares accepted bytes and checks stability across stalls.
   initial begin
      exp_t e;
      exp_t held;
      logic held_v;
      held_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            held_v = 1'b0;
         end else begin
            if (bus.out_valid && held_v)
               check("hold", {21'd0, bus.out_data, bus.out_lane, bus.out_sop}, {21'd0, held});
            held_v = bus.out_valid && !bus.out_ready;
            held   = {bus.out_data, bus.out_lane, bus.out_sop};
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_byte: got data=%0h lane=%0d, want nothing", bus.out_data, bus.out_lane);
               end else begin
                  e = exp_q.pop_front();
                  check("byte_data", bus.out_data, e.d);
                  check("byte_lane", bus.out_lane, e.lane);
                  check("byte_sop",  bus.out_sop,  e.sop);
               end
               seen++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      logic [31:0] s;
      reset         = 1'b0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.clr_flags = 1'b0;
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready",  bus.in_ready,  0);
      check("rst_level",     bus.level,     0);
      check("rst_overflow",  bus.overflow,  0);
      check("rst_skew",      bus.skew_err,  0);
      check("rst_err_count", bus.err_count, 0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_out_lane",  bus.out_lane,  0);
      check("rst_out_sop",   bus.out_sop,   0);
      step();
      reset = 1'b1;
      step();
      check("rel_in_ready", bus.in_ready, 1);

      // Three stripes, continuous sink.
      bus.out_ready = 1'b1;
      push_stripe(32'h04030201);
      push_stripe(32'h08070605);
      push_stripe(32'h12111009);
      drain("drain_basic");

      // Fill with stalled sink, fifth stripe overflows.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++)
            s[k*8 +: 8] = 8'h20 + 8'(4*i + k);
         push_stripe(s);
      end
      check("full_in_ready", bus.in_ready, 0);
      check("full_level",    bus.level,    4);
      push_stripe(32'h33323130);
      check("full_overflow", bus.overflow, 1);
      check("full_level2",   bus.level,    4);
      bus.out_ready = 1'b1;
      drain("drain_full");

      // Skewed stripe is dropped.
      bus.in_valid = 4'b0111;
      bus.in_data  = 32'hAABBCCDD;
      step();
      bus.in_valid = '0;
      check("skew_flag",  bus.skew_err,  1);
      check("skew_level", bus.level,     0);
      check("skew_count", bus.err_count, ERR_ONE);
      repeat (3) step();
      check("skew_no_out", bus.out_valid, 0);

      // Reset after two bytes of a stripe.
      base = seen;
      push_stripe(32'h43424140);
      for (int i = 0; i < 20 && seen < base + 2; i++)
         step();
      check("midrst_two_bytes", (seen == base + 2) ? 1 : 0, 1);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_level",     bus.level,     0);
      check("midrst_in_ready",  bus.in_ready,  0);
      check("midrst_skew",      bus.skew_err,  0);
      step();
      reset = 1'b1;
      step();
      push_stripe(32'h53525150);
      drain("drain_after_rst");

      // Alternating sink readiness.
      bus.out_ready = 1'b0;
      push_stripe(32'h63626160);
      for (int i = 0; i < 16; i++) begin
         bus.out_ready = (i % 2 == 0);
         step();
      end
      bus.out_ready = 1'b1;
      drain("drain_toggle");

      // Saturate the skew counter, then clear with a competing skew event.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_stripe(32'h73727170 + 32'(i));
      for (int i = 0; i < 300; i++) begin
         bus.in_valid = 4'b0001;
         step();
      end
      bus.in_valid = '0;
      check("sat_count",    bus.err_count, ERR_SAT);
      check("sat_skew",     bus.skew_err,  1);
      check("sat_overflow", bus.overflow,  1);
      check("sat_level",    bus.level,     4);
      bus.clr_flags = 1'b1;
      bus.in_valid  = 4'b0111;
      step();
      bus.clr_flags = 1'b0;
      bus.in_valid  = '0;
      check("clr_overflow", bus.overflow,  0);
      check("clr_skew",     bus.skew_err,  0);
      check("clr_count",    bus.err_count, 0);
      bus.out_ready = 1'b1;
      drain("drain_final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/byte_unstriping_rx_p.md
BYTE_UNSTRIPING_RX_P -- requirements
Module: byte_unstriping_rx_p

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the lane and output byte width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of input lanes (power of two, 2..8).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the number of stripes buffered (power of two, >=2).
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on rising edge.
REQ-005 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, width LANES: per-lane byte valid.
REQ-007 The block SHALL have port in_data, input, width LANES*DATA_W: lane k occupies bits [k*DATA_W +: DATA_W].
REQ-008 The block SHALL have port in_ready, output, width 1: stripe buffer can accept.
REQ-009 The block SHALL have port out_valid, output, width 1: out_data holds a valid byte.
REQ-010 The block SHALL have port out_ready, input, width 1: sink accepts the byte.
REQ-011 The block SHALL have port out_data, output, width DATA_W: serialised byte.
REQ-012 The block SHALL have port out_lane, output, width clog2(LANES): source lane of out_data.
REQ-013 The block SHALL have port out_sop, output, width 1: high on lane-0 byte of each stripe.
REQ-014 The block SHALL have port level, output, width clog2(DEPTH)+1: stripes stored.
REQ-015 The block SHALL have port clr_flags, input, width 1: synchronous clear of the sticky flags and err_count.
REQ-016 The block SHALL have ports overflow, skew_err, output, width 1: sticky error flags.
REQ-017 The block SHALL have port err_count, output, width 8: saturating skew-error count.

Function
REQ-018 A stripe SHALL be pushed on an edge where in_valid is all-ones and in_ready=1.
REQ-019 in_ready SHALL equal (level < DEPTH), evaluated on the pre-edge level; no push when full, even if a pop occurs in the same cycle.
REQ-020 If in_valid is all-ones and in_ready=0, the stripe SHALL be discarded and overflow set at the next edge.
REQ-021 If in_valid is nonzero and not all-ones, the stripe SHALL be discarded, skew_err set and err_count incremented at the next edge.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; level SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-023 Output FSM states SHALL be IDLE (out_valid=0) and SEND (out_valid=1).
REQ-024 IDLE->SEND SHALL occur when level>0, with lane index 0.
REQ-025 In SEND, out_data SHALL be lane[idx] of the head stripe, out_lane=idx, and out_sop=(idx==0).
REQ-026 On out_valid&out_ready, idx SHALL increment.
REQ-027 At idx=LANES-1 the head SHALL be popped and idx reset to 0; the FSM stays in SEND if level after pop >0, else goes to IDLE.
REQ-028 out_data, out_lane and out_sop SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Latency SHALL be one cycle: a stripe pushed into an empty buffer at edge N gives out_valid=1 after edge N+1.
REQ-030 Output order SHALL be stripe FIFO order, lanes 0..LANES-1 within each stripe; one byte per cycle SHALL be sustained under continuous out_ready.
REQ-031 clr_flags SHALL have priority over a same-cycle flag set.

Reset
REQ-032 reset=0 SHALL immediately force the following, regardless of the clock: FSM=IDLE, idx=0, pointers=0, level=0, out_valid=0, out_data=0, out_lane=0, out_sop=0, in_ready=0 while reset is asserted, overflow=0, skew_err=0, err_count=0.
REQ-033 Reset mid-stripe SHALL discard all buffered and partially sent data; the first stripe after release SHALL start at lane 0.

Configuration
REQ-034 With macro UNSTRIPE_ERR_COUNT_EN defined, err_count SHALL count skew errors, saturating at 255, and be cleared by clr_flags.
REQ-035 Without UNSTRIPE_ERR_COUNT_EN, err_count SHALL be tied to 0, no counter logic SHALL exist, and skew_err behaviour SHALL be unchanged.

Verification
REQ-036 Bench SHALL cover: defaults, out_ready=1, stripes {01,02,03,04},{05,06,07,08},{09,10,11,12} -> out_data 01..12 in order, out_lane 0,1,2,3 repeating, out_sop on 01/05/09.
REQ-037 Bench SHALL cover: out_ready=0 with 5 stripes pushed -> in_ready=0 after 4, level=4, overflow=1; then out_ready=1 -> exactly 16 bytes from the first 4 stripes.
REQ-038 Bench SHALL cover: in_valid=4'b0111 -> skew_err=1, no output, level=0, err_count=1 (macro on) or 0 (macro off).
REQ-039 Bench SHALL cover: reset=0 after 2 bytes of a stripe -> out_valid=0 immediately, level=0; the next stripe emits lane 0 first.
REQ-040 Bench SHALL cover: out_ready pattern 1,0,1,0 -> each byte held while stalled, no loss or duplication.
REQ-041 Bench SHALL cover: 300 skew errors -> err_count=255; clr_flags pulse -> overflow, skew_err, err_count =0 next edge.
